apb_uart_bridge_master: RTL and testbench

- Byte-stream-to-APB initiator.
- Parses command frames arriving from a UART receiver byte interface and issues single APB read/write transfers on a peripheral APB port (GPIO, timer, confreg, UART, ...).
- Returns response bytes to a UART transmitter byte interface.
- Gives host-side debug access to the APB peripheral map, acting as a second bus initiator beside the CPU.

---
 rtl/apb_uart_bridge_master.sv | 248 ++++++++++++++++++++++++
 tb/tb_apb_uart_bridge_master.sv | 394 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/apb_uart_bridge_master.sv
// -----------------------------------------------------------------------------
// apb_uart_bridge_master
//
// Byte-stream to APB initiator. Command frames from a UART receiver byte port
// are parsed into single APB read/write transfers; a response is returned on
// a UART transmitter byte port. Gives a host debug access to the APB map as a
// second initiator beside the CPU.
//
// Frames (big-endian):
//   write : 0x57 A3 A2 A1 A0 D3 D2 D1 D0  -> response 0x4B
//   read  : 0x52 A3 A2 A1 A0              -> response prdata[31:24..7:0]
//   other opcode byte                     -> response 0x45
//   access timeout (optional)             -> response 0x54
//
// Optional feature macro: APB_BRIDGE_TIMEOUT_EN
//   When defined, an ACCESS phase with no apb_ack for TIMEOUT_CYCLES cycles is
//   aborted. When undefined, ACCESS waits for apb_ack indefinitely.
//
// Parameters:
//   ADDR_W          width of apb_paddr (<= 32)
//   TIMEOUT_CYCLES  ACCESS cycles before abort (only with the macro defined)
//
// Ports:
//   apb_pclk     in   clock
//   apb_prstn    in   synchronous active-low reset
//   rx_data      in   received byte
//   rx_valid     in   rx_data valid
//   rx_ready     out  byte accepted when rx_valid && rx_ready
//   tx_data      out  response byte
//   tx_valid     out  tx_data valid
//   tx_ready     in   byte consumed when tx_valid && tx_ready
//   apb_psel     out  APB select
//   apb_paddr    out  APB address
//   apb_pwrite   out  1 = write
//   apb_penable  out  APB access phase
//   apb_pwdata   out  write data
//   apb_prdata   in   read data
//   apb_ack      in   transfer complete, sampled while apb_penable = 1
//   busy         out  high in any state other than IDLE
// -----------------------------------------------------------------------------
module apb_uart_bridge_master #(
    parameter int ADDR_W = 32
`ifdef APB_BRIDGE_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CYCLES = 255
`endif
) (
    input  logic              apb_pclk,
    input  logic              apb_prstn,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              apb_psel,
    output logic [ADDR_W-1:0] apb_paddr,
    output logic              apb_pwrite,
    output logic              apb_penable,
    output logic [31:0]       apb_pwdata,
    input  logic [31:0]       apb_prdata,
    input  logic              apb_ack,
    output logic              busy
);

    localparam logic [7:0] OP_WRITE = 8'h57;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h45;
`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam logic [7:0] RSP_TOUT = 8'h54;
    localparam int         TO_W     = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                      $clog2(TIMEOUT_CYCLES + 1) : 8;
    // r_tcnt holds the number of earlier ACCESS cycles without ack, so the
    // abort fires in the TIMEOUT_CYCLES-th ACCESS cycle.
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
`endif

    typedef enum logic [2:0] {
        StIdle,
        StAddr,
        StWdata,
        StSetup,
        StAccess,
        StResp
    } state_t;

    state_t      r_state;
    logic [1:0]  r_cnt;
    logic [1:0]  r_resp_last;
    logic        r_write;
    logic [31:0] r_shadow;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic        r_psel;
    logic        r_penable;
    logic        r_tx_valid;
    logic [7:0]  r_tx_data;
`ifdef APB_BRIDGE_TIMEOUT_EN
    logic [TO_W-1:0] r_tcnt;
`endif

    logic w_rx_fire;
    logic w_tx_fire;

    // rx_ready is forced low while reset is asserted, whatever the state.
    assign rx_ready  = apb_prstn &&
                       ((r_state == StIdle) || (r_state == StAddr) || (r_state == StWdata));
    assign w_rx_fire = rx_valid && rx_ready;
    assign w_tx_fire = r_tx_valid && tx_ready;

    assign apb_psel    = r_psel;
    assign apb_penable = r_penable;
    assign apb_pwrite  = r_write;
    assign apb_paddr   = r_shadow[ADDR_W-1:0];
    assign apb_pwdata  = r_wdata;
    assign tx_valid    = r_tx_valid;
    assign tx_data     = r_tx_data;
    assign busy        = (r_state != StIdle);

    always_ff @(posedge apb_pclk) begin
        if (!apb_prstn) begin
            r_state     <= StIdle;
            r_cnt       <= 2'd0;
            r_resp_last <= 2'd0;
            r_write     <= 1'b0;
            r_shadow    <= 32'd0;
            r_wdata     <= 32'd0;
            r_rdata     <= 32'd0;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_tx_valid  <= 1'b0;
            r_tx_data   <= 8'd0;
`ifdef APB_BRIDGE_TIMEOUT_EN
            r_tcnt      <= '0;
`endif
        end else begin
            unique case (r_state)
                StIdle: begin
                    if (w_rx_fire) begin
                        r_cnt <= 2'd0;
                        if (rx_data == OP_WRITE) begin
                            r_write <= 1'b1;
                            r_state <= StAddr;
                        end else if (rx_data == OP_READ) begin
                            r_write <= 1'b0;
                            r_state <= StAddr;
                        end else begin
                            r_tx_data   <= RSP_ERR;
                            r_tx_valid  <= 1'b1;
                            r_resp_last <= 2'd0;
                            r_state     <= StResp;
                        end
                    end
                end

                StAddr: begin
                    if (w_rx_fire) begin
                        r_shadow <= {r_shadow[23:0], rx_data};
                        r_cnt    <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            if (r_write) begin
                                r_state <= StWdata;
                            end else begin
                                r_psel  <= 1'b1;
                                r_state <= StSetup;
                            end
                        end
                    end
                end

                StWdata: begin
                    if (w_rx_fire) begin
                        r_wdata <= {r_wdata[23:0], rx_data};
                        r_cnt   <= r_cnt + 2'd1;
                        if (r_cnt == 2'd3) begin
                            r_psel  <= 1'b1;
                            r_state <= StSetup;
                        end
                    end
                end

                StSetup: begin
                    r_penable <= 1'b1;
`ifdef APB_BRIDGE_TIMEOUT_EN
                    r_tcnt    <= '0;
`endif
                    r_state   <= StAccess;
                end

                StAccess: begin
                    // An ack in the same cycle the timeout is reached still wins.
                    if (apb_ack && r_penable) begin
                        r_psel     <= 1'b0;
                        r_penable  <= 1'b0;
                        r_tx_valid <= 1'b1;
                        r_cnt      <= 2'd0;
                        if (r_write) begin
                            r_tx_data   <= RSP_OK;
                            r_resp_last <= 2'd0;
                        end else begin
                            r_tx_data   <= apb_prdata[31:24];
                            r_rdata     <= {apb_prdata[23:0], 8'd0};
                            r_resp_last <= 2'd3;
                        end
                        r_state <= StResp;
                    end
`ifdef APB_BRIDGE_TIMEOUT_EN
                    else if (r_tcnt == TO_LAST) begin
                        r_psel      <= 1'b0;
                        r_penable   <= 1'b0;
                        r_tx_valid  <= 1'b1;
                        r_tx_data   <= RSP_TOUT;
                        r_resp_last <= 2'd0;
                        r_cnt       <= 2'd0;
                        r_state     <= StResp;
                    end else begin
                        r_tcnt <= r_tcnt + 1'b1;
                    end
`endif
                end

                StResp: begin
                    if (w_tx_fire) begin
                        if (r_cnt == r_resp_last) begin
                            r_tx_valid <= 1'b0;
                            r_cnt      <= 2'd0;
                            r_state    <= StIdle;
                        end else begin
                            // Remaining read bytes sit MSB-first in r_rdata.
                            r_cnt     <= r_cnt + 2'd1;
                            r_tx_data <= r_rdata[31:24];
                            r_rdata   <= {r_rdata[23:0], 8'd0};
                        end
                    end
                end

                default: begin
                    r_psel     <= 1'b0;
                    r_penable  <= 1'b0;
                    r_tx_valid <= 1'b0;
                    r_state    <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_apb_uart_bridge_master.sv
`timescale 1ns/1ps
module tb_apb_uart_bridge_master;

`ifdef APB_BRIDGE_TIMEOUT_EN
    localparam int TO_CYC  = 4;
    localparam int MAX_DLY = 3;
`else
    localparam int MAX_DLY = 6;
`endif

    logic        apb_pclk = 1'b0;
    logic        apb_prstn;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic        apb_psel;
    logic [31:0] apb_paddr;
    logic        apb_pwrite;
    logic        apb_penable;
    logic [31:0] apb_pwdata;
    logic [31:0] apb_prdata;
    logic        apb_ack;
    logic        busy;

    always #5 apb_pclk = ~apb_pclk;

    apb_uart_bridge_master #(
        .ADDR_W(32)
`ifdef APB_BRIDGE_TIMEOUT_EN
        , .TIMEOUT_CYCLES(TO_CYC)
`endif
    ) u_dut (
        .apb_pclk   (apb_pclk),
        .apb_prstn  (apb_prstn),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .apb_psel   (apb_psel),
        .apb_paddr  (apb_paddr),
        .apb_pwrite (apb_pwrite),
        .apb_penable(apb_penable),
        .apb_pwdata (apb_pwdata),
        .apb_prdata (apb_prdata),
        .apb_ack    (apb_ack),
        .busy       (busy)
    );

    typedef struct {
        logic [31:0] addr;
        logic        write;
        logic [31:0] wdata;
    } apb_xfer_t;

    // Reference model state: expected APB transfers and expected tx bytes.
    apb_xfer_t   exp_apb[$];
    logic [7:0]  exp_tx[$];
    logic [31:0] m_last_wdata = 32'd0;

    int          n_vec = 0;
    int          n_err = 0;

    int          ack_delay_fix = -1;
    bit          prdata_fix_en = 1'b0;
    logic [31:0] prdata_fix    = 32'd0;
    bit          tx_rand       = 1'b0;
    bit          rx_gap_en     = 1'b0;
    bit          abort_apb     = 1'b0;
    bit          stuck         = 1'b0;
    int          stall_at      = -1;
    int          stall_left    = 0;
    int          n_hold56      = 0;
    int          tx_count      = 0;
    logic [31:0] tx_last       = 32'd0;
    int          setup_count   = 0;

    int          sl_st    = 0;
    int          sl_cnt   = 0;
    int          sl_delay = 0;
    apb_xfer_t   sl_cur;
    logic [31:0] sl_prd;

    logic        sk_hold_prev = 1'b0;
    logic [7:0]  sk_hold_data = 8'd0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    // Called just after a falling edge; returns just after the falling edge
    // that follows the accepting rising edge.
    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        if (stuck) return;
        rx_data  = b;
        rx_valid = 1'b1;
        while (!rx_ready && n < 500) begin
            @(negedge apb_pclk);
            n++;
        end
        if (!rx_ready) begin
            check_eq("rx_accept", rx_ready, 1);
            stuck    = 1'b1;
            rx_valid = 1'b0;
            return;
        end
        @(negedge apb_pclk);
        rx_valid = 1'b0;
        if (rx_gap_en) repeat ($urandom_range(0, 2)) @(negedge apb_pclk);
    endtask

    task automatic do_frame(input bit wr, input logic [31:0] addr, input logic [31:0] data);
        apb_xfer_t t;
        t.addr  = addr;
        t.write = wr;
        t.wdata = wr ? data : m_last_wdata;
        if (wr) m_last_wdata = data;
        exp_apb.push_back(t);
        send_byte(wr ? 8'h57 : 8'h52);
        for (int i = 3; i >= 0; i--) send_byte(addr[8*i +: 8]);
        if (wr) for (int i = 3; i >= 0; i--) send_byte(data[8*i +: 8]);
    endtask

    task automatic wait_idle();
        int n = 0;
        while (!(exp_tx.size() == 0 && !busy && sl_st == 0) && n < 1000) begin
            @(negedge apb_pclk);
            n++;
        end
        if (n >= 1000) begin
            check_eq("drain_busy", busy, 0);
            check_eq("drain_txq", exp_tx.size(), 0);
            stuck = 1'b1;
        end else begin
            check_eq("idle_rx_ready", rx_ready, 1);
            check_eq("idle_psel", apb_psel, 0);
            check_eq("idle_apbq", exp_apb.size(), 0);
        end
    endtask

    // APB completer: checks the SETUP/ACCESS sequence and answers with ack.
    initial begin
        apb_ack    = 1'b0;
        apb_prdata = 32'd0;
        forever begin
            @(negedge apb_pclk);
            if (abort_apb) begin
                sl_st     = 0;
                apb_ack   = 1'b0;
                abort_apb = 1'b0;
            end else begin
                case (sl_st)
                    0: begin
                        apb_ack = 1'b0;
                        if (apb_psel) begin
                            setup_count++;
                            check_eq("setup_penable", apb_penable, 0);
                            check_eq("setup_expected", exp_apb.size() > 0, 1);
                            if (exp_apb.size() > 0) begin
                                sl_cur = exp_apb.pop_front();
                                check_eq("setup_paddr", apb_paddr, sl_cur.addr);
                                check_eq("setup_pwrite", apb_pwrite, sl_cur.write);
                                check_eq("setup_pwdata", apb_pwdata, sl_cur.wdata);
                            end
                            sl_delay = (ack_delay_fix >= 0) ? ack_delay_fix :
                                       $urandom_range(0, MAX_DLY);
                            sl_cnt = 0;
                            sl_st  = 1;
                        end
                    end
                    1: begin
                        if (!apb_psel) begin
`ifdef APB_BRIDGE_TIMEOUT_EN
                            check_eq("timeout_penable_cycles", sl_cnt, TO_CYC);
`else
                            check_eq("access_psel_held", apb_psel, 1);
`endif
                            sl_st = 0;
                        end else begin
                            check_eq("access_penable", apb_penable, 1);
                            check_eq("access_paddr", apb_paddr, sl_cur.addr);
                            sl_cnt++;
                            if (sl_cnt == sl_delay + 1) begin
                                sl_prd     = prdata_fix_en ? prdata_fix : $urandom();
                                apb_prdata = sl_prd;
                                apb_ack    = 1'b1;
                                if (sl_cur.write) begin
                                    exp_tx.push_back(8'h4B);
                                end else begin
                                    for (int i = 3; i >= 0; i--) exp_tx.push_back(sl_prd[8*i +: 8]);
                                end
                                sl_st = 2;
                            end
                        end
                    end
                    default: begin
                        apb_ack    = 1'b0;
                        apb_prdata = $urandom();
                        check_eq("post_ack_psel", apb_psel, 0);
                        check_eq("post_ack_penable", apb_penable, 0);
                        check_eq("post_ack_tx_valid", tx_valid, 1);
                        sl_st = 0;
                    end
                endcase
            end
        end
    end

    // UART tx sink: random or stalled tx_ready, checks bytes and hold stability.
    initial begin
        tx_ready = 1'b0;
        forever begin
            @(negedge apb_pclk);
            if (sk_hold_prev) begin
                check_eq("tx_hold_valid", tx_valid, 1);
                check_eq("tx_hold_data", tx_data, sk_hold_data);
            end
            if (stall_left > 0 && tx_count == stall_at) begin
                tx_ready = 1'b0;
                if (tx_valid) begin
                    stall_left--;
                    if (tx_data == 8'h56) n_hold56++;
                end
            end else if (tx_rand) begin
                tx_ready = ($urandom_range(0, 3) != 0);
            end else begin
                tx_ready = 1'b1;
            end
            if (tx_valid && tx_ready) begin
                check_eq("tx_expected", exp_tx.size() > 0, 1);
                if (exp_tx.size() > 0) check_eq("tx_byte", tx_data, exp_tx.pop_front());
                tx_last = {tx_last[23:0], tx_data};
                tx_count++;
            end
            sk_hold_prev = tx_valid && !tx_ready;
            sk_hold_data = tx_data;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          sc;
        int          tc;
        int          n;
        logic [7:0]  bad;
        logic [31:0] a;
        logic [31:0] d;

        apb_prstn = 1'b0;
        rx_valid  = 1'b0;
        rx_data   = 8'd0;
        repeat (3) @(negedge apb_pclk);

        check_eq("rst_psel", apb_psel, 0);
        check_eq("rst_penable", apb_penable, 0);
        check_eq("rst_pwrite", apb_pwrite, 0);
        check_eq("rst_tx_valid", tx_valid, 0);
        check_eq("rst_busy", busy, 0);
        check_eq("rst_paddr", apb_paddr, 0);
        check_eq("rst_pwdata", apb_pwdata, 0);
        check_eq("rst_tx_data", tx_data, 0);
        check_eq("rst_rx_ready", rx_ready, 0);
        apb_prstn = 1'b1;
        @(negedge apb_pclk);
        check_eq("post_rst_rx_ready", rx_ready, 1);

        // Directed write, ack after 3 wait cycles.
        ack_delay_fix = 3;
        do_frame(1'b1, 32'hBFEB_0004, 32'h0000_0013);
        wait_idle();
        check_eq("write_resp", tx_last[7:0], 8'h4B);

        // Directed read with a 5-cycle tx stall on byte 2.
        ack_delay_fix = 1;
        prdata_fix_en = 1'b1;
        prdata_fix    = 32'h1234_5678;
        stall_at      = tx_count + 2;
        stall_left    = 5;
        n_hold56      = 0;
        do_frame(1'b0, 32'hBFED_0008, 32'd0);
        wait_idle();
        check_eq("read_bytes", tx_last, 32'h1234_5678);
        check_eq("stall_on_56", n_hold56, 5);
        prdata_fix_en = 1'b0;

        // Bad opcode, then a normal read.
        sc = setup_count;
        exp_tx.push_back(8'h45);
        send_byte(8'h41);
        wait_idle();
        check_eq("bad_op_resp", tx_last[7:0], 8'h45);
        check_eq("bad_op_no_psel", setup_count, sc);
        ack_delay_fix = 0;
        do_frame(1'b0, 32'h0000_0000, 32'd0);
        wait_idle();

        // Reset in the middle of ACCESS.
        ack_delay_fix = 20;
        tc = tx_count;
        do_frame(1'b0, $urandom(), 32'd0);
        n = 0;
        while (!apb_penable && n < 50) begin
            @(negedge apb_pclk);
            n++;
        end
        check_eq("reach_access", apb_penable, 1);
        @(negedge apb_pclk);
        #1;
        apb_prstn = 1'b0;
        abort_apb = 1'b1;
        #1;
        check_eq("midrst_rx_ready", rx_ready, 0);
        @(negedge apb_pclk);
        check_eq("midrst_psel", apb_psel, 0);
        check_eq("midrst_penable", apb_penable, 0);
        check_eq("midrst_tx_valid", tx_valid, 0);
        check_eq("midrst_busy", busy, 0);
        check_eq("midrst_pwdata", apb_pwdata, 0);
        #1;
        apb_prstn    = 1'b1;
        m_last_wdata = 32'd0;
        exp_apb.delete();
        repeat (10) @(negedge apb_pclk);
        check_eq("midrst_no_resp", tx_count, tc);
        ack_delay_fix = -1;
        do_frame(1'b1, 32'hBFEB_0010, 32'hCAFE_F00D);
        wait_idle();
        check_eq("post_rst_write_resp", tx_last[7:0], 8'h4B);

`ifdef APB_BRIDGE_TIMEOUT_EN
        // Ack never comes: abort after TO_CYC ACCESS cycles.
        ack_delay_fix = 100;
        exp_tx.push_back(8'h54);
        do_frame(1'b0, 32'hBFEC_0020, 32'd0);
        wait_idle();
        check_eq("timeout_resp", tx_last[7:0], 8'h54);
        // Ack in the last allowed cycle wins.
        ack_delay_fix = TO_CYC - 1;
        prdata_fix_en = 1'b1;
        prdata_fix    = 32'hA5C3_0F96;
        do_frame(1'b0, 32'hBFEC_0024, 32'd0);
        wait_idle();
        check_eq("late_ack_bytes", tx_last, 32'hA5C3_0F96);
        prdata_fix_en = 1'b0;
`endif

        // Two back-to-back writes with rx_valid held high.
        ack_delay_fix = -1;
        rx_gap_en     = 1'b0;
        sc            = setup_count;
        do_frame(1'b1, 32'h1000_0000, 32'h1111_1111);
        do_frame(1'b1, 32'h1000_0004, 32'h2222_2222);
        wait_idle();
        check_eq("b2b_resp", tx_last[15:0], 16'h4B4B);
        check_eq("b2b_setups", setup_count - sc, 2);

        // Randomized traffic.
        tx_rand   = 1'b1;
        rx_gap_en = 1'b1;
        for (int k = 0; k < 60 && !stuck; k++) begin
            n = $urandom_range(0, 9);
            a = $urandom();
            d = $urandom();
            if (n == 0) begin
                wait_idle();
                bad = 8'($urandom_range(0, 255));
                while (bad == 8'h57 || bad == 8'h52) bad = 8'($urandom_range(0, 255));
                exp_tx.push_back(8'h45);
                send_byte(bad);
            end else begin
                do_frame(n < 5, a, d);
            end
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
